// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline (stall / flush / interrupt entry / ERET).
// Latency: write enables and flushes are combinational from state and inputs; interrupt accept to int_ack is DRAIN_CYCLES+1.
// Backpressure: a data-memory wait freezes every pipeline register; state and drain counter hold.
// Optional build macro PIPE_CTRL_STALLCNT_EN adds the stall_cnt / int_cnt performance counters.

module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       int_req,
  input  logic       eret,
  output logic       PCW,
  output logic       IFIDW,
  output logic       IDEXW,
  output logic       EXMEMW,
  output logic       MEMWBW,
  output logic       rst1,
  output logic       rst2,
  output logic       rst3,
  output logic       rst4,
  output logic [1:0] pc_sel,
  output logic       epc_w,
  output logic       int_ack,
  output logic       int_mask
`ifdef PIPE_CTRL_STALLCNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] int_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_VECTOR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_DRAIN = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_VECTOR = 2'd2;
  localparam logic [1:0] PC_EPC    = 2'd3;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_int_mask;

  // Hazard detection terms
  logic w_mem_stall;
  logic w_int_pending;
  logic w_load_use;

  // One-hot RUN-state decisions after priority resolution
  logic w_run;
  logic w_run_accept;
  logic w_run_branch;
  logic w_run_eret;
  logic w_run_load_use;
  logic w_drain_last;

  assign w_mem_stall   = mem_req && !mem_ready;
  assign w_int_pending = int_req && !r_int_mask;
  assign w_load_use    = idex_memread && (idex_rt != 5'd0) &&
                         ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // Priority chain: mem stall > interrupt > branch > ERET > load-use.
  // Interrupt acceptance wins over a branch or ERET in the same cycle; the
  // discarded instruction is re-fetched after the handler returns via EPC.
  assign w_run          = (r_state == S_RUN) && !w_mem_stall;
  assign w_run_accept   = w_run && w_int_pending;
  assign w_run_branch   = w_run && !w_int_pending && branch_taken;
  assign w_run_eret     = w_run && !w_int_pending && !branch_taken && eret;
  assign w_run_load_use = w_run && !w_int_pending && !branch_taken && !eret && w_load_use;

  // Last draining cycle: counter already at 1 and the memory is not holding us
  assign w_drain_last   = (r_state == S_DRAIN) && !w_mem_stall && (r_cnt == LP_ONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a memory stall holds RUN and DRAIN, VECTOR always advances
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        if (w_run_accept) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_last) begin
          w_next = S_VECTOR;
        end
      end
      S_VECTOR: begin
        w_next = S_RUN;
      end
      default: begin
        w_next = S_RUN;
      end
    endcase
  end

  // Drain counter: loaded on accept, counts down on every unstalled DRAIN cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_run_accept) begin
      r_cnt <= LP_DRAIN;
    end else if ((r_state == S_DRAIN) && !w_mem_stall) begin
      r_cnt <= r_cnt - LP_ONE;
    end
  end

  // Interrupt mask: set when the handler is entered, cleared only by ERET
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_mask <= 1'b0;
    end else if (r_state == S_VECTOR) begin
      r_int_mask <= 1'b1;
    end else if (w_run_eret) begin
      r_int_mask <= 1'b0;
    end
  end

  assign int_mask = r_int_mask;

  // Output decode from state and resolved hazards; reset forces a flushed, frozen pipe
  always_comb begin
    PCW     = 1'b1;
    IFIDW   = 1'b1;
    IDEXW   = 1'b1;
    EXMEMW  = 1'b1;
    MEMWBW  = 1'b1;
    rst1    = 1'b0;
    rst2    = 1'b0;
    rst3    = 1'b0;
    rst4    = 1'b0;
    pc_sel  = PC_PLUS4;
    epc_w   = 1'b0;
    int_ack = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          PCW    = 1'b0;
          IFIDW  = 1'b0;
          IDEXW  = 1'b0;
          EXMEMW = 1'b0;
          MEMWBW = 1'b0;
        end else if (w_run_accept) begin
          // Save the PC of the instruction in IF/ID and kill IF/ID and ID/EX;
          // older instructions in EX/MEM/WB keep flowing out.
          epc_w = 1'b1;
          PCW   = 1'b0;
          rst1  = 1'b1;
          rst2  = 1'b1;
        end else if (w_run_branch) begin
          pc_sel = PC_BRANCH;
          rst1   = 1'b1;
          rst2   = 1'b1;
        end else if (w_run_eret) begin
          pc_sel = PC_EPC;
          rst1   = 1'b1;
        end else if (w_run_load_use) begin
          // Hold PC and IF/ID for one cycle and inject a bubble into ID/EX
          PCW   = 1'b0;
          IFIDW = 1'b0;
          rst2  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_mem_stall) begin
          PCW    = 1'b0;
          IFIDW  = 1'b0;
          IDEXW  = 1'b0;
          EXMEMW = 1'b0;
          MEMWBW = 1'b0;
        end else begin
          PCW  = 1'b0;
          rst1 = 1'b1;
          rst2 = 1'b1;
        end
      end
      S_VECTOR: begin
        // MEM holds a bubble here, so a pending memory wait cannot apply
        pc_sel  = PC_VECTOR;
        rst1    = 1'b1;
        int_ack = 1'b1;
      end
      default: begin
        PCW    = 1'b0;
        IFIDW  = 1'b0;
        IDEXW  = 1'b0;
        EXMEMW = 1'b0;
        MEMWBW = 1'b0;
      end
    endcase

    if (!rst) begin
      PCW     = 1'b0;
      IFIDW   = 1'b0;
      IDEXW   = 1'b0;
      EXMEMW  = 1'b0;
      MEMWBW  = 1'b0;
      rst1    = 1'b1;
      rst2    = 1'b1;
      rst3    = 1'b1;
      rst4    = 1'b1;
      pc_sel  = PC_PLUS4;
      epc_w   = 1'b0;
      int_ack = 1'b0;
    end
  end

`ifdef PIPE_CTRL_STALLCNT_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_int_cnt;

  // Count cycles in which fetch is held, excluding the vectoring cycle; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (!PCW && (r_state != S_VECTOR)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Count interrupt acknowledges; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_cnt <= '0;
    end else if (int_ack) begin
      r_int_cnt <= r_int_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign int_cnt   = r_int_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with DRAIN_CYCLES=3.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Expected vectors are hand-derived from the sequencing rules.

module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       int_req;
  logic       eret;
  logic       PCW, IFIDW, IDEXW, EXMEMW, MEMWBW;
  logic       rst1, rst2, rst3, rst4;
  logic [1:0] pc_sel;
  logic       epc_w, int_ack, int_mask;
`ifdef PIPE_CTRL_STALLCNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] int_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .int_req      (int_req),
    .eret         (eret),
    .PCW          (PCW),
    .IFIDW        (IFIDW),
    .IDEXW        (IDEXW),
    .EXMEMW       (EXMEMW),
    .MEMWBW       (MEMWBW),
    .rst1         (rst1),
    .rst2         (rst2),
    .rst3         (rst3),
    .rst4         (rst4),
    .pc_sel       (pc_sel),
    .epc_w        (epc_w),
    .int_ack      (int_ack),
    .int_mask     (int_mask)
`ifdef PIPE_CTRL_STALLCNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .int_cnt      (int_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare {PCW,IFIDW,IDEXW,EXMEMW,MEMWBW}, {rst1..rst4}, pc_sel, epc_w, int_ack, int_mask
  task automatic chk(input string tag, input logic [4:0] ew, input logic [3:0] er,
                     input logic [1:0] eps, input logic ee, input logic ea, input logic em);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {PCW, IFIDW, IDEXW, EXMEMW, MEMWBW, rst1, rst2, rst3, rst4, pc_sel, epc_w, int_ack, int_mask};
    exp = {ew, er, eps, ee, ea, em};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    idex_memread = 1'b0;
    idex_rt      = 5'd0;
    ifid_rs      = 5'd0;
    ifid_rt      = 5'd0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    int_req      = 1'b0;
    eret         = 1'b0;
  endtask

  // Advance to the next falling edge (inputs are applied after this returns)
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();

    // Reset state
    nxt(); #1;
    chk("reset_forced", 5'b00000, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);

    nxt(); rst = 1'b1; #1;
    chk("run_default", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Load-use via rs
    nxt(); idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; #1;
    chk("load_use_rs", 5'b00111, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0);

    // Load-use via rt
    nxt(); ifid_rs = 5'd0; ifid_rt = 5'd5; #1;
    chk("load_use_rt", 5'b00111, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0);

    // Load to r0 never stalls
    nxt(); idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    chk("load_r0_no_stall", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // No dependency
    nxt(); idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd4; #1;
    chk("load_no_dep", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Branch overrides load-use
    nxt(); idex_rt = 5'd5; ifid_rs = 5'd5; branch_taken = 1'b1; #1;
    chk("branch_over_lu", 5'b11111, 4'b1100, 2'd1, 1'b0, 1'b0, 1'b0);

    // Mem stall for 3 cycles, with a branch pending (stall wins)
    for (int i = 0; i < 3; i++) begin
      nxt(); idle(); mem_req = 1'b1; mem_ready = 1'b0; branch_taken = (i == 0); #1;
      chk($sformatf("mem_stall_%0d", i), 5'b00000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    nxt(); branch_taken = 1'b0; mem_ready = 1'b1; #1;
    chk("mem_ready_resume", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Interrupt entry: T0 accept (branch and eret discarded)
    nxt(); idle(); int_req = 1'b1; branch_taken = 1'b1; eret = 1'b1; #1;
    chk("int_T0_accept", 5'b01111, 4'b1100, 2'd0, 1'b1, 1'b0, 1'b0);
    // T1..T3 drain; int_req drops, a stray branch at T2 is ignored
    nxt(); idle(); #1;
    chk("int_T1_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); branch_taken = 1'b1; int_req = 1'b1; #1;
    chk("int_T2_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); idle(); #1;
    chk("int_T3_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); #1;
    chk("int_T4_vector", 5'b11111, 4'b1000, 2'd2, 1'b0, 1'b1, 1'b0);
    nxt(); #1;
    chk("int_T5_masked", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); int_req = 1'b1; #1;
    chk("int_T6_ignored", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); int_req = 1'b0; #1;
    chk("int_T7_run", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); eret = 1'b1; #1;
    chk("eret_T8", 5'b11111, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b1);
    nxt(); eret = 1'b0; #1;
    chk("eret_T9_unmasked", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Interrupt with mem stall at T2..T3 -> int_ack at T6
    nxt(); int_req = 1'b1; #1;
    chk("ms_T0_accept", 5'b01111, 4'b1100, 2'd0, 1'b1, 1'b0, 1'b0);
    nxt(); int_req = 1'b0; #1;
    chk("ms_T1_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    chk("ms_T2_frozen", 5'b00000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); #1;
    chk("ms_T3_frozen", 5'b00000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); mem_ready = 1'b1; #1;
    chk("ms_T4_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); mem_req = 1'b0; #1;
    chk("ms_T5_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    // VECTOR ignores a memory wait
    nxt(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    chk("ms_T6_vector", 5'b11111, 4'b1000, 2'd2, 1'b0, 1'b1, 1'b0);
    nxt(); #1;
    chk("ms_T7_run_stall", 5'b00000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);

    // Reset clears the mask
    nxt(); idle(); rst = 1'b0; #1;
    chk("rst_mask_forced", 5'b00000, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); rst = 1'b1; #1;
    chk("rst_mask_release", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-DRAIN (counter=2)
    nxt(); int_req = 1'b1; #1;
    chk("rd_T0_accept", 5'b01111, 4'b1100, 2'd0, 1'b1, 1'b0, 1'b0);
    nxt(); int_req = 1'b0; #1;
    chk("rd_T1_drain", 5'b01111, 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); rst = 1'b0; #1;
    chk("rd_T2_reset", 5'b00000, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
    nxt(); rst = 1'b1; #1;
    chk("rd_release_run", 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk($sformatf("rd_stays_run_%0d", i), 5'b11111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline. It drives the write enables (PCW, IFIDW, IDEXW, EXMEMW, MEMWBW) and synchronous flush strobes (rst1..rst4) consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use stalls, taken-branch flushes and data-memory wait stalls.
- Runs the interrupt entry sequence: drain, save EPC, vector.
- Handles ERET.

Parameters:
DRAIN_CYCLES, 3, cycles spent draining EX/MEM/WB before vectoring (1..15)
CNT_W, 4, width of drain counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
idex_memread  input  1  instruction in ID/EX is a load
idex_rt  input  5  load destination register in ID/EX
ifid_rs  input  5  rs of instruction in IF/ID
ifid_rt  input  5  rt of instruction in IF/ID
branch_taken  input  1  EX resolved a taken branch/jump
mem_req  input  1  MEM stage accessing data memory
mem_ready  input  1  data memory completes this cycle
int_req  input  1  level interrupt request
eret  input  1  ERET decoded in IF/ID
PCW  output  1  PC write enable
IFIDW  output  1  IF/ID write enable
IDEXW  output  1  ID/EX write enable
EXMEMW  output  1  EX/MEM write enable
MEMWBW  output  1  MEM/WB write enable
rst1  output  1  flush IF/ID (synchronous, consumed by register)
rst2  output  1  flush ID/EX
rst3  output  1  flush EX/MEM
rst4  output  1  flush MEM/WB
pc_sel  output  2  0=PC+4, 1=branch target, 2=int vector, 3=EPC
epc_w  output  1  EPC latches current IF/ID PC
int_ack  output  1  one-cycle acknowledge on vectoring
int_mask  output  1  interrupts masked (in handler)

Behaviour:
- States: RUN, DRAIN, VECTOR. All outputs are Moore/Mealy combinational from state plus inputs, except int_mask and the counter, which are registered.
- While rst=0 (async):
  - state=RUN, int_mask=0, counter=0.
  - Outputs forced: all W=0, rst1..rst4=1, pc_sel=0, epc_w=0, int_ack=0.
- Default in RUN: all W=1, rst1..4=0, pc_sel=0.
- RUN priority, highest first (exactly one applies per cycle):
  1. Mem stall (mem_req && !mem_ready): all W=0, all rst=0, pc_sel=0. Full freeze. State and counter hold. Also applies in DRAIN.
  2. Interrupt accept (int_req && !int_mask):
     - epc_w=1, PCW=0, rst1=1, rst2=1; EXMEMW=MEMWBW=1.
     - counter<=DRAIN_CYCLES; next=DRAIN.
     - Any branch_taken/eret this cycle is discarded.
  3. Branch (branch_taken): pc_sel=1, PCW=1, rst1=1, rst2=1.
  4. ERET (eret): pc_sel=3, PCW=1, rst1=1; int_mask<=0 at clock edge.
  5. Load-use (idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt)): PCW=0, IFIDW=0, rst2=1 (one bubble), others W=1.
- DRAIN:
  - PCW=0, rst1=1, rst2=1, EXMEMW=MEMWBW=IDEXW=1.
  - Counter decrements each non-stalled cycle. When it reaches 1 and is not stalled: next=VECTOR.
  - int_req is ignored; branch_taken cannot occur (ID/EX bubbled) and is ignored.
- VECTOR (1 cycle, unaffected by mem stall since MEM holds a bubble):
  - pc_sel=2, PCW=1, rst1=1, int_ack=1; int_mask<=1; next=RUN.
- int_mask: set only in VECTOR, cleared only by ERET or reset. int_req while masked is ignored; no latching.
- Latency: interrupt accept to int_ack = DRAIN_CYCLES+1 cycles; first handler fetch on the following cycle.
- int_req deasserting during DRAIN does not abort entry.

Optional Feature:
PIPE_CTRL_STALLCNT_EN:
- Defined: adds output stall_cnt[31:0], reset to 0. Increments once per cycle in which PCW=0 and state!=VECTOR, wrapping 0xFFFFFFFF->0. Also adds output int_cnt[15:0], counting int_ack pulses with wrap.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset: hold rst=0 mid-DRAIN (counter=2), release -> state RUN, all W=1, rst1..4=0, int_mask=0 on the first edge after release.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle PCW=0, IFIDW=0, rst2=1. With idex_rt=0 -> no stall.
- Branch + load-use same cycle: branch_taken=1 -> pc_sel=1, rst1=rst2=1, PCW=1.
- Mem stall: mem_req=1, mem_ready=0 for 3 cycles -> all W=0 for exactly 3 cycles; normal operation resumes when mem_ready=1.
- Interrupt, DRAIN_CYCLES=3, int_mask=0:
  - int_req=1 -> epc_w=1 at T0, DRAIN T1..T3, VECTOR at T4 (pc_sel=2, int_ack=1), int_mask=1 from T5.
  - Second int_req at T6 is ignored.
  - eret at T8 -> pc_sel=3, int_mask=0 at T9.
- Mem stall in DRAIN: mem_ready=0 for 2 cycles at T2 -> int_ack moves to T6.
